fetch_align: RTL and testbench
==============================

FETCH_ALIGN -- requirements
Module: fetch_align

Interface
REQ-001 Parameter FW, default 32, fetch word width in bits; legal values are 32 and 64.
REQ-002 Parameter DEPTH, default 8, queue depth in 16-bit halfword entries; must be a power of 2 and at least 2*FW/16.
REQ-003 Parameter RV, default 32, program counter width in bits.
REQ-004 Port clk, input, 1, sole clock; all state is updated on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port fetch_valid, input, 1, fetch word offered.
REQ-007 Port fetch_ready, output, 1, queue can accept a full fetch word.
REQ-008 Port fetch_data, input, FW, fetch word; halfword i is bits [16i+15:16i], and the lowest halfword is earliest in program order.
REQ-009 Port flush, input, 1, discard all queued and in-flight halfwords and redirect.
REQ-010 Port flush_pc, input, RV, new halfword-aligned PC; bit 0 is ignored.
REQ-011 Port ins_valid, output, 1, head instruction valid.
REQ-012 Port ins_ready, input, 1, consumer takes the head this cycle.
REQ-013 Port ins, output, 16, head halfword.
REQ-014 Port ins_pc, output, RV, byte address of the head halfword.
REQ-015 Port pre_br, output, 1, head is a PC-relative branch or jump.
REQ-016 Port pre_jmp, output, 1, head is a register-indirect jump (jr or jalr).
REQ-017 Port count, output, log2(DEPTH)+1, number of occupied entries.

Function
REQ-018 A push SHALL occur on a cycle with fetch_valid & fetch_ready & !flush.
REQ-019 A pop SHALL occur on a cycle with ins_valid & ins_ready & !flush.
REQ-020 fetch_ready SHALL be high when the run flag is set and (DEPTH - count) >= FW/16, using count before that cycle's pop.
REQ-021 A push SHALL write FW/16 - skip halfwords in ascending order at the tail, where skip is the drop count pending from the last flush; skip SHALL then clear to 0.
REQ-022 A pop SHALL advance the head by one entry and add 2 to ins_pc, modulo 2^RV.
REQ-023 Push and pop in the same cycle SHALL both take effect; count changes by (pushed - 1).
REQ-024 Head and tail pointers SHALL wrap modulo DEPTH with no loss or duplication of entries.
REQ-025 A written halfword SHALL first appear on ins/ins_valid in the cycle after the push edge; there is no bypass.
REQ-026 ins_valid SHALL equal (count != 0); ins SHALL be driven from the head entry and is don't-care when ins_valid is 0.
REQ-027 On flush, the next edge SHALL set count to 0, set head equal to tail, and load ins_pc with {flush_pc[RV-1:1],0}.
REQ-028 On flush, skip SHALL load flush_pc[log2(FW/8)-1:1], so that the first word pushed after the flush, fetched from the FW-aligned address, drops its leading halfwords.
REQ-029 flush SHALL have priority over a simultaneous push and pop; the fetch word offered in the flush cycle SHALL be discarded.
REQ-030 Back-to-back flushes SHALL each take effect; the last one determines ins_pc and skip.
REQ-031 pre_br SHALL be set when ins_valid and either:
- ins[1:0]=01 with ins[15:13] in {001,101,110,111}; or
- ins[1:0]=11 with ins[15:14]=11.
REQ-032 pre_jmp SHALL be set when ins_valid and ins[1:0]=10, ins[15:13]=100 and ins[6:2]=00000.
REQ-033 pre_br and pre_jmp SHALL be combinational from the head and SHALL be 0 when ins_valid is 0.
REQ-034 The consumer MAY hold ins_ready high continuously; with ins_valid low, no pop SHALL occur.

Reset
REQ-035 While reset is high, the following SHALL hold: count=0, head=tail=0, ins_pc=0, skip=0, run flag=0, ins_valid=0, fetch_ready=0, pre_br=0, pre_jmp=0.
REQ-036 The run flag SHALL set on the first rising edge after reset deasserts; fetch_ready may assert from the following cycle.
REQ-037 Reset asserted mid-operation SHALL discard all entries immediately and asynchronously, with no output glitch to a valid state while reset is high.
REQ-038 Queue storage contents need not be reset.

Verification
REQ-039 FW=32, DEPTH=8: flush with flush_pc=0x100; push 0x0001_8082 from 0x100; hold ins_ready=1.
- Required: ins=0x8082 with pc 0x100, then ins=0x0001 with pc 0x102.
- pre_jmp=1 on 0x8082 only.
REQ-040 flush_pc=0x102, then push 0xA001_1234.
- Required: the only output is ins=0xA001 with pc 0x102, pre_br=1.
- count reaches 1, never 2.
REQ-041 ins_ready=0; push words until fetch_ready drops.
- Required: fetch_ready=0 at count=8 (DEPTH=8) and also at count=7.
- Then assert ins_ready: 8 pops in order, pc incrementing by 2.
REQ-042 Continuous push and pop over 5 wraps of the pointers.
- Required: the output stream equals the input halfword stream exactly.
- count stays within [0,8] throughout.
REQ-043 flush asserted in the same cycle as fetch_valid & fetch_ready and ins_ready with count=3.
- Required: next cycle count=0, ins_valid=0, ins_pc=flush_pc.
- The word offered in the flush cycle never appears on ins.
REQ-044 Assert reset asynchronously mid-stream with count=5.
- Required: ins_valid=0 immediately.
- After release: fetch_ready=0 for one cycle, then 1; ins_pc=0.

Source files
------------

// File: rtl/fetch_align.sv
// fetch_align: halfword realignment queue between the fetch unit and decode.
// Accepts FW-bit fetch words, drops the leading halfwords of the first word
// after a redirect, and presents one 16-bit halfword per pop with its PC and
// a light branch/jump predecode.
module fetch_align #(
  parameter int unsigned FW    = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned RV    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic [FW-1:0]            fetch_data,
  input  logic                     flush,
  input  logic [RV-1:0]            flush_pc,
  output logic                     ins_valid,
  input  logic                     ins_ready,
  output logic [15:0]              ins,
  output logic [RV-1:0]            ins_pc,
  output logic                     pre_br,
  output logic                     pre_jmp,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned HW  = FW / 16;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned SKW = $clog2(FW / 8) - 1;

  logic [15:0]    r_mem [DEPTH];
  logic [AW-1:0]  r_head;
  logic [AW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic [RV-1:0]  r_pc;
  logic [SKW-1:0] r_skip;
  logic           r_run;

  logic [CW-1:0]  w_free;
  logic [CW-1:0]  w_npush;
  logic [FW-1:0]  w_data;
  logic           w_push;
  logic           w_pop;

  // Handshake and occupancy; readiness uses occupancy before this cycle's pop
  assign w_free      = CW'(DEPTH) - r_count;
  assign fetch_ready = r_run && (w_free >= CW'(HW));
  assign ins_valid   = (r_count != '0);
  assign w_push      = fetch_valid & fetch_ready & ~flush;
  assign w_pop       = ins_valid & ins_ready & ~flush;
  assign w_npush     = w_push ? (CW'(HW) - CW'(r_skip)) : '0;
  // Shift the skipped leading halfwords out so kept halfwords start at bit 0
  assign w_data      = fetch_data >> {r_skip, 4'b0000};

  assign ins    = r_mem[r_head];
  assign ins_pc = r_pc;
  assign count  = r_count;

  // Predecode of the head halfword, forced low when the queue is empty
  always_comb begin
    pre_br  = 1'b0;
    pre_jmp = 1'b0;
    if (ins_valid) begin
      if (ins[1:0] == 2'b01) begin
        pre_br = (ins[15:13] == 3'b001) || (ins[15:13] == 3'b101) ||
                 (ins[15:13] == 3'b110) || (ins[15:13] == 3'b111);
      end else if (ins[1:0] == 2'b11) begin
        pre_br = (ins[15:14] == 2'b11);
      end
      pre_jmp = (ins[1:0] == 2'b10) && (ins[15:13] == 3'b100) &&
                (ins[6:2] == 5'b00000);
    end
  end

  // Queue storage: write the kept halfwords in ascending order at the tail
  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < HW; j++) begin
      if (CW'(j) < w_npush) begin
        r_mem[r_tail + AW'(j)] <= w_data[16*j +: 16];
      end
    end
  end

  // Pointers, occupancy, head PC, pending skip and run flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_pc    <= '0;
      r_skip  <= '0;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (flush) begin
        r_count <= '0;
        r_head  <= r_tail;
        r_pc    <= {flush_pc[RV-1:1], 1'b0};
        r_skip  <= flush_pc[SKW:1];
      end else begin
        r_tail  <= r_tail + AW'(w_npush);
        r_head  <= r_head + AW'(w_pop);
        r_count <= r_count + w_npush - CW'(w_pop);
        if (w_pop) begin
          r_pc <= r_pc + RV'(2);
        end
        if (w_push) begin
          r_skip <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// Self-checking bench for fetch_align (FW=32, DEPTH=8, RV=32) with a
// halfword/PC scoreboard filled on accepted fetch words and drained on pops.
module tb_fetch_align;

  localparam int unsigned FW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned RV    = 32;

  typedef struct {
    logic [15:0]   hw;
    logic [RV-1:0] pc;
  } sb_entry_t;

  logic          clk;
  logic          reset;
  logic          fetch_valid;
  logic          fetch_ready;
  logic [FW-1:0] fetch_data;
  logic          flush;
  logic [RV-1:0] flush_pc;
  logic          ins_valid;
  logic          ins_ready;
  logic [15:0]   ins;
  logic [RV-1:0] ins_pc;
  logic          pre_br;
  logic          pre_jmp;
  logic [3:0]    count;

  int n_chk;
  int n_err;
  int n_pops;

  sb_entry_t     sb_q[$];
  logic [RV-1:0] m_pc;
  logic          m_skip;
  logic          m_run;
  logic [15:0]   seq;

  fetch_align #(.FW(FW), .DEPTH(DEPTH), .RV(RV)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready),
    .fetch_data (fetch_data),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .ins        (ins),
    .ins_pc     (ins_pc),
    .pre_br     (pre_br),
    .pre_jmp    (pre_jmp),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_br(input logic [15:0] h);
    if (h[1:0] == 2'b01)
      return (h[15:13] == 3'b001) || (h[15:13] == 3'b101) ||
             (h[15:13] == 3'b110) || (h[15:13] == 3'b111);
    if (h[1:0] == 2'b11)
      return h[15:14] == 2'b11;
    return 1'b0;
  endfunction

  function automatic logic exp_jmp(input logic [15:0] h);
    return (h[1:0] == 2'b10) && (h[15:13] == 3'b100) && (h[6:2] == 5'b00000);
  endfunction

  // Reference run flag: clears on reset, sets on the first edge after release
  always @(posedge clk or posedge reset) begin
    if (reset) m_run <= 1'b0;
    else       m_run <= 1'b1;
  end

  // Mid-cycle monitor: compare outputs to the model, then apply this cycle's handshakes
  always @(negedge clk) begin
    int   sz;
    logic m_ready;
    sb_entry_t e;
    sz = sb_q.size();
    if (reset) begin
      chk("rst_valid", 64'(ins_valid), 64'd0);
      chk("rst_ready", 64'(fetch_ready), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_br", 64'(pre_br), 64'd0);
      chk("rst_jmp", 64'(pre_jmp), 64'd0);
      sb_q.delete();
      m_pc   = '0;
      m_skip = 1'b0;
    end else begin
      m_ready = m_run && ((DEPTH - sz) >= 2);
      chk("count", 64'(count), 64'(sz));
      chk("cnt_range", 64'(count <= 4'd8), 64'd1);
      chk("valid", 64'(ins_valid), 64'(sz != 0));
      chk("ready", 64'(fetch_ready), 64'(m_ready));
      if (sz != 0) begin
        e = sb_q[0];
        chk("ins", 64'(ins), 64'(e.hw));
        chk("ins_pc", 64'(ins_pc), 64'(e.pc));
        chk("pre_br", 64'(pre_br), 64'(exp_br(e.hw)));
        chk("pre_jmp", 64'(pre_jmp), 64'(exp_jmp(e.hw)));
      end else begin
        chk("idle_br", 64'(pre_br), 64'd0);
        chk("idle_jmp", 64'(pre_jmp), 64'd0);
      end
      if (flush) begin
        sb_q.delete();
        m_pc   = {flush_pc[RV-1:1], 1'b0};
        m_skip = flush_pc[1];
      end else begin
        if (sz != 0 && ins_ready) begin
          void'(sb_q.pop_front());
          n_pops++;
        end
        if (fetch_valid && m_ready) begin
          if (!m_skip) begin
            sb_q.push_back('{hw: fetch_data[15:0], pc: m_pc});
            m_pc = m_pc + 2;
          end
          sb_q.push_back('{hw: fetch_data[31:16], pc: m_pc});
          m_pc   = m_pc + 2;
          m_skip = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input logic [RV-1:0] pc);
    flush    = 1'b1;
    flush_pc = pc;
    tick();
    flush = 1'b0;
  endtask

  task automatic push_word(input logic [FW-1:0] d);
    logic rdy;
    logic done;
    done        = 1'b0;
    fetch_valid = 1'b1;
    fetch_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      rdy = fetch_ready;
      tick();
      done = rdy;
    end
    fetch_valid = 1'b0;
    chk("push_accept", 64'(done), 64'd1);
  endtask

  function automatic logic [FW-1:0] next_word();
    logic [FW-1:0] w;
    w   = {seq + 16'd1, seq};
    seq = seq + 16'd2;
    return w;
  endfunction

  task automatic fill_until_full();
    logic stop;
    stop        = 1'b0;
    fetch_valid = 1'b1;
    for (int i = 0; i < 20 && !stop; i++) begin
      fetch_data = next_word();
      tick();
      stop = !fetch_ready;
    end
    fetch_valid = 1'b0;
  endtask

  initial begin
    int p0;
    n_chk = 0; n_err = 0; n_pops = 0;
    seq = 16'h1000;
    reset = 1'b1; fetch_valid = 1'b0; fetch_data = '0;
    flush = 1'b0; flush_pc = '0; ins_ready = 1'b0;
    m_pc = '0; m_skip = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("post_rst_ready0", 64'(fetch_ready), 64'd0);
    chk("post_rst_pc", 64'(ins_pc), 64'd0);
    tick();
    chk("post_rst_ready1", 64'(fetch_ready), 64'd1);

    // Aligned redirect: 0x8082 (jr) then 0x0001
    ins_ready = 1'b1;
    do_flush(32'h100);
    push_word(32'h0001_8082);
    chk("r39_ins0", 64'(ins), 64'h8082);
    chk("r39_pc0", 64'(ins_pc), 64'h100);
    chk("r39_jmp0", 64'(pre_jmp), 64'd1);
    tick();
    chk("r39_ins1", 64'(ins), 64'h0001);
    chk("r39_pc1", 64'(ins_pc), 64'h102);
    chk("r39_jmp1", 64'(pre_jmp), 64'd0);
    repeat (2) tick();

    // Misaligned redirect drops the low halfword
    do_flush(32'h102);
    push_word(32'hA001_1234);
    chk("r40_cnt", 64'(count), 64'd1);
    chk("r40_ins", 64'(ins), 64'hA001);
    chk("r40_pc", 64'(ins_pc), 64'h102);
    chk("r40_br", 64'(pre_br), 64'd1);
    repeat (3) tick();

    // Fill to 8, then drain in order
    ins_ready = 1'b0;
    do_flush(32'h200);
    fill_until_full();
    chk("r41_cnt8", 64'(count), 64'd8);
    chk("r41_ready8", 64'(fetch_ready), 64'd0);
    p0 = n_pops;
    ins_ready = 1'b1;
    repeat (10) tick();
    chk("r41_pops", 64'(n_pops - p0), 64'd8);
    chk("r41_pc_end", 64'(ins_pc), 64'h210);

    // Fill to 7 from a misaligned redirect
    ins_ready = 1'b0;
    do_flush(32'h302);
    fill_until_full();
    chk("r41_cnt7", 64'(count), 64'd7);
    chk("r41_ready7", 64'(fetch_ready), 64'd0);
    ins_ready = 1'b1;
    repeat (9) tick();

    // Streaming over many pointer wraps with random back-pressure
    do_flush(32'h1000);
    p0 = n_pops;
    fetch_valid = 1'b1;
    for (int i = 0; i < 120; i++) begin
      fetch_data = {16'($urandom), 16'($urandom)};
      ins_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    fetch_valid = 1'b0;
    ins_ready   = 1'b1;
    repeat (10) tick();
    chk("r42_wraps", 64'(n_pops - p0 >= 40), 64'd1);
    chk("r42_drained", 64'(count), 64'd0);

    // Flush colliding with push and pop at count 3
    ins_ready = 1'b0;
    do_flush(32'h402);
    push_word(next_word());
    push_word(next_word());
    chk("r43_pre_cnt", 64'(count), 64'd3);
    chk("r43_pre_ready", 64'(fetch_ready), 64'd1);
    fetch_valid = 1'b1;
    fetch_data  = 32'hDEAD_BEEF;
    ins_ready   = 1'b1;
    flush       = 1'b1;
    flush_pc    = 32'h500;
    tick();
    flush       = 1'b0;
    fetch_valid = 1'b0;
    chk("r43_cnt", 64'(count), 64'd0);
    chk("r43_valid", 64'(ins_valid), 64'd0);
    chk("r43_pc", 64'(ins_pc), 64'h500);
    repeat (3) tick();

    // Asynchronous reset mid-stream at count 5
    ins_ready = 1'b0;
    do_flush(32'h602);
    push_word(next_word());
    push_word(next_word());
    push_word(next_word());
    chk("r44_pre_cnt", 64'(count), 64'd5);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("r44_valid", 64'(ins_valid), 64'd0);
    chk("r44_cnt", 64'(count), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("r44_ready0", 64'(fetch_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("r44_ready1", 64'(fetch_ready), 64'd1);
    chk("r44_pc", 64'(ins_pc), 64'd0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
